// File: rtl/psum_drain_ctrl_if.sv
// psum_drain_ctrl_if
//   Bundles the drain controller's memory port and its output stream.
//   master : drain controller side (drives read/write requests and o_dat/o_vld,
//            receives read data and downstream ready).
//   slave  : memory + writeback side (the opposite directions).
interface psum_drain_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mem_radd;
    logic                  mem_rden;
    logic [DATA_WIDTH-1:0] mem_odat;
    logic                  mem_oval;
    logic [ADDR_WIDTH-1:0] mem_wadd;
    logic                  mem_wren;
    logic [DATA_WIDTH-1:0] mem_idat;
    logic [DATA_WIDTH-1:0] o_dat;
    logic                  o_vld;
    logic                  i_rdy;

    modport master (
        output mem_radd, mem_rden, mem_wadd, mem_wren, mem_idat, o_dat, o_vld,
        input  mem_odat, mem_oval, i_rdy
    );

    modport slave (
        input  mem_radd, mem_rden, mem_wadd, mem_wren, mem_idat, o_dat, o_vld,
        output mem_odat, mem_oval, i_rdy
    );
endinterface

// File: rtl/psum_drain_ctrl.sv
// psum_drain_ctrl
//   Drains the partial-sum memory after accumulation: reads addresses 0..N-1
//   in order, applies optional per-lane ReLU, streams words out through a
//   small skid FIFO and optionally zeroes each drained address.
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     i_start               start pulse (ignored while busy)
//     i_conf_outputsize     words per kernel group minus 1
//     i_conf_numgroup       number of kernel groups
//     i_conf_relu_en        clamp negative lanes to 0
//     i_conf_clear_en       write zero back to each drained address
//     bus (master)          memory read/write port + o_dat/o_vld/i_rdy stream
//     o_busy, o_done        drain in progress / one-cycle completion pulse
module psum_drain_ctrl #(
    parameter int BIT_WIDTH  = 8,
    parameter int REG_WIDTH  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_DELAY  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [REG_WIDTH-1:0] i_conf_outputsize,
    input  logic [REG_WIDTH-1:0] i_conf_numgroup,
    input  logic                 i_conf_relu_en,
    input  logic                 i_conf_clear_en,
    psum_drain_ctrl_if.master    bus,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int LANES = DATA_WIDTH / BIT_WIDTH;
    localparam int CW    = $clog2(FIFO_DEPTH + 1) + 1;
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [REG_WIDTH-1:0]  r_total, r_rd_cnt, r_sh_cnt;
    logic                  r_relu_en, r_clear_en;
    logic [CW-1:0]         r_inflight, r_count;
    logic [PW-1:0]         r_wp, r_rp;
    logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic                  r_wren;
    logic [ADDR_WIDTH-1:0] r_wadd;

    logic [REG_WIDTH-1:0]  w_total;
    logic [CW:0]           w_occ;
    logic                  w_rden, w_last_rd, w_ret, w_full, w_push, w_vld, w_pop;
    logic [DATA_WIDTH-1:0] w_proc;

    // Product is deliberately truncated to REG_WIDTH bits.
    assign w_total   = (i_conf_outputsize + REG_WIDTH'(1)) * i_conf_numgroup;

    // Credit: every issued read owns a FIFO slot until it is popped.
    assign w_occ     = (CW+1)'(r_count) + (CW+1)'(r_inflight);
    assign w_rden    = (r_state == S_READ) && (w_occ < (CW+1)'(FIFO_DEPTH));
    assign w_last_rd = w_rden && (r_rd_cnt == r_total - REG_WIDTH'(1));

    // Returns outside a drain are stray and ignored.
    assign w_ret     = bus.mem_oval && (r_state != S_IDLE);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_push    = w_ret && !w_full;
    assign w_vld     = (r_count != '0);
    assign w_pop     = w_vld && bus.i_rdy;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_proc[g*BIT_WIDTH +: BIT_WIDTH] =
            (r_relu_en && bus.mem_odat[g*BIT_WIDTH + BIT_WIDTH - 1]) ?
            '0 : bus.mem_odat[g*BIT_WIDTH +: BIT_WIDTH];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = (w_total == '0) ? S_DONE : S_READ;
            S_READ:  if (w_last_rd) w_state_nxt = S_FLUSH;
            S_FLUSH: if (r_inflight == '0 && r_count == '0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_total    <= '0;
            r_rd_cnt   <= '0;
            r_sh_cnt   <= '0;
            r_relu_en  <= 1'b0;
            r_clear_en <= 1'b0;
            r_inflight <= '0;
            r_count    <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_wren     <= 1'b0;
            r_wadd     <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == S_IDLE && i_start) begin
                r_total    <= w_total;
                r_relu_en  <= i_conf_relu_en;
                r_clear_en <= i_conf_clear_en;
                r_rd_cnt   <= '0;
                r_sh_cnt   <= '0;
            end else begin
                if (w_rden) r_rd_cnt <= r_rd_cnt + REG_WIDTH'(1);
                if (w_ret)  r_sh_cnt <= r_sh_cnt + REG_WIDTH'(1);
            end

            case ({w_rden, w_ret})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   if (r_inflight != '0) r_inflight <= r_inflight - CW'(1);
                default: ;
            endcase

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase

            if (w_push) r_wp <= (r_wp == PW'(FIFO_DEPTH - 1)) ? '0 : r_wp + PW'(1);
            if (w_pop)  r_rp <= (r_rp == PW'(FIFO_DEPTH - 1)) ? '0 : r_rp + PW'(1);

            // Zero write trails the read return by a cycle, so it can never
            // overtake the read of the same address.
            r_wren <= w_ret && r_clear_en;
            r_wadd <= ADDR_WIDTH'(r_sh_cnt);
        end
    end

    // Storage needs no reset: o_dat is masked until a word is present.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wp] <= w_proc;
    end

    assign bus.mem_rden = w_rden;
    assign bus.mem_radd = ADDR_WIDTH'(r_rd_cnt);
    assign bus.mem_wren = r_wren;
    assign bus.mem_wadd = r_wadd;
    assign bus.mem_idat = '0;
    assign bus.o_vld    = w_vld;
    assign bus.o_dat    = w_vld ? r_fifo[r_rp] : '0;
    assign o_busy       = (r_state == S_READ) || (r_state == S_FLUSH);
    assign o_done       = (r_state == S_DONE);
endmodule

// File: tb/tb_psum_drain_ctrl.sv
module tb_psum_drain_ctrl;
    localparam int BW = 8, DW = 32, AW = 32, RW = 32, FD = 4;

    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    logic          i_start = 0;
    logic [RW-1:0] os = 0, ng = 0;
    logic          relu = 0, clr = 0;
    logic          busy, done;

    psum_drain_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    psum_drain_ctrl #(.BIT_WIDTH(BW), .REG_WIDTH(RW), .DATA_WIDTH(DW),
                      .ADDR_WIDTH(AW), .FIFO_DEPTH(FD), .MEM_DELAY(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start),
        .i_conf_outputsize(os), .i_conf_numgroup(ng),
        .i_conf_relu_en(relu), .i_conf_clear_en(clr),
        .bus(bus), .o_busy(busy), .o_done(done));

    int errors = 0, checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: each lane is a signed number; ReLU zeroes negative lanes.
    function automatic logic [DW-1:0] model(logic [DW-1:0] w, logic relu_on);
        logic [DW-1:0] r;
        logic signed [BW-1:0] lane;
        r = '0;
        for (int i = 0; i < DW/BW; i++) begin
            lane = w[i*BW +: BW];
            r[i*BW +: BW] = (relu_on && lane < 0) ? '0 : lane;
        end
        return r;
    endfunction

    // Memory model: read data returns mem_delay cycles after the request.
    logic [DW-1:0] mem [0:63];
    int mem_delay = 1;
    typedef struct { int due; logic [DW-1:0] d; } rd_t;
    rd_t rq[$];

    initial begin
        bus.mem_oval = 0;
        bus.mem_odat = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_oval = 0;
            bus.mem_odat = '0;
            if (!rst_n) rq.delete();
            else if (rq.size() > 0 && rq[0].due == cyc) begin
                bus.mem_oval = 1;
                bus.mem_odat = rq[0].d;
                void'(rq.pop_front());
            end
            @(negedge clk);
            if (rst_n) begin
                if (bus.mem_rden) rq.push_back('{cyc + mem_delay, mem[bus.mem_radd[5:0]]});
                if (bus.mem_wren) mem[bus.mem_wadd[5:0]] = '0;
            end
        end
    end

    // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
    int rdy_mode = 0;
    initial begin
        bus.i_rdy = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.i_rdy = 1;
                1:       bus.i_rdy = ($urandom_range(0, 3) != 0);
                default: bus.i_rdy = 0;
            endcase
        end
    end

    // Scoreboard monitor.
    logic [DW-1:0] exp_q[$];
    int n_issued = 0, n_popped = 0, n_wren = 0, rexp_addr = 0, wexp_addr = 0;
    logic stalled = 0;
    logic [DW-1:0] stall_dat = '0, last_out = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
                continue;
            end
            if (bus.mem_rden) begin
                chk("rd_addr", bus.mem_radd, rexp_addr);
                chk("credit", (n_issued + 1 - n_popped) <= FD, 1);
                rexp_addr++;
                n_issued++;
            end
            if (bus.mem_wren) begin
                chk("wr_addr", bus.mem_wadd, wexp_addr);
                chk("wr_data", bus.mem_idat, 0);
                wexp_addr++;
                n_wren++;
            end
            if (stalled) chk("stall_hold", {bus.o_vld, bus.o_dat}, {1'b1, stall_dat});
            if (bus.o_vld && bus.i_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word: got %0h expected none", bus.o_dat);
                end else if (bus.o_dat !== exp_q[0]) begin
                    errors++;
                    $display("FAIL out_word: got %0h expected %0h", bus.o_dat, exp_q[0]);
                    void'(exp_q.pop_front());
                end else void'(exp_q.pop_front());
                last_out = bus.o_dat;
                n_popped++;
            end
            stalled   = bus.o_vld && !bus.i_rdy;
            stall_dat = bus.o_dat;
        end
    end

    task automatic start(input int o_s, input int n_g, input logic r, input logic c,
                         input logic accept, output int t);
        int n;
        @(posedge clk); #1;
        os = o_s; ng = n_g; relu = r; clr = c;
        i_start = 1;
        t = cyc;
        if (accept) begin
            n = (o_s + 1) * n_g;
            rexp_addr = 0; wexp_addr = 0; n_issued = 0; n_popped = 0; n_wren = 0;
            for (int a = 0; a < n; a++) exp_q.push_back(model(mem[a], r));
        end
        @(posedge clk); #1;
        i_start = 0;
    endtask

    task automatic wait_done(input int t, input int exp_lat, input string nm);
        int k = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            k++;
            if (k > 3000) begin
                checks++; errors++;
                $display("FAIL %s_timeout: got no o_done expected o_done", nm);
                return;
            end
        end
        if (exp_lat >= 0) chk(nm, cyc - t, exp_lat);
        chk("busy_at_done", busy, 0);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_rden"}, bus.mem_rden, 0);
        chk({nm, "_wren"}, bus.mem_wren, 0);
        chk({nm, "_radd"}, bus.mem_radd, 0);
        chk({nm, "_wadd"}, bus.mem_wadd, 0);
        chk({nm, "_idat"}, bus.mem_idat, 0);
        chk({nm, "_odat"}, bus.o_dat, 0);
        chk({nm, "_ovld"}, bus.o_vld, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, n;
        logic r, c;
        for (int a = 0; a < 64; a++) mem[a] = a * 32'h01010101;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk); #1 rst_n = 1;

        // Basic drain: N=8, delay 1, clear on
        rdy_mode = 0; mem_delay = 1;
        start(3, 2, 0, 1, 1, t);
        wait_done(t, 8 + 1 + 3, "basic_latency");
        repeat (2) @(posedge clk);
        chk("basic_all_out", exp_q.size(), 0);
        chk("basic_wren_cnt", n_wren, 8);
        for (int a = 0; a < 8; a++) chk("basic_cleared", mem[a], 0);
        chk("basic_untouched", mem[8], 32'h08080808);

        // ReLU on / off
        mem[0] = 32'h80FF7F01;
        start(0, 1, 1, 0, 1, t);
        wait_done(t, 1 + 1 + 3, "relu_latency");
        chk("relu_on", last_out, 32'h00007F01);
        start(0, 1, 0, 0, 1, t);
        wait_done(t, 5, "relu_off_latency");
        chk("relu_off", last_out, 32'h80FF7F01);

        // Backpressure: N=16, delay 2, 10-cycle stall mid-drain
        mem_delay = 2;
        for (int a = 0; a < 16; a++) mem[a] = $urandom;
        r = 1'($urandom_range(0, 1));
        start(7, 2, r, 1, 1, t);
        repeat (5) @(posedge clk);
        rdy_mode = 2;
        repeat (10) @(posedge clk);
        rdy_mode = 0;
        wait_done(t, -1, "bp");
        chk("bp_all_out", exp_q.size(), 0);
        chk("bp_count", n_popped, 16);

        // Zero-size start
        start(5, 0, 0, 1, 1, t);
        wait_done(t, 1, "zero_latency");
        chk("zero_no_reads", n_issued, 0);

        // Randomized drains with random backpressure
        for (int it = 0; it < 4; it++) begin
            mem_delay = $urandom_range(1, 2);
            for (int a = 0; a < 32; a++) mem[a] = $urandom;
            r = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            n = $urandom_range(0, 5);
            t2 = $urandom_range(1, 4);
            rdy_mode = 1;
            start(n, t2, r, c, 1, t);
            wait_done(t, -1, "rand");
            rdy_mode = 0;
            chk("rand_all_out", exp_q.size(), 0);
            chk("rand_wren_cnt", n_wren, c ? (n + 1) * t2 : 0);
        end

        // Start while busy is ignored
        mem_delay = 1; rdy_mode = 0;
        for (int a = 0; a < 32; a++) mem[a] = $urandom;
        start(3, 2, 0, 0, 1, t);
        start(9, 5, 1, 1, 0, t2);
        wait_done(t, 12, "busy_start_latency");
        chk("busy_start_count", n_popped, 8);
        chk("busy_start_all_out", exp_q.size(), 0);

        // Reset mid-drain, then drain again from address 0
        start(15, 1, 0, 1, 1, t);
        repeat (4) @(posedge clk);
        #1 rst_n = 0;
        #1 chk_outputs_zero("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        start(3, 1, 0, 0, 1, t);
        wait_done(t, 4 + 1 + 3, "restart_latency");
        chk("restart_all_out", exp_q.size(), 0);
        chk("restart_count", n_popped, 4);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
